spi_slave_param: RTL
====================

# spi_slave_param

Parametrised SPI slave, the next generation of the team's 10-bit SPI slave. It deserialises command frames of PAYLOAD_W+2 bits from MOSI into a parallel word for the downstream RAM/register interface. On read-data commands it serialises a PAYLOAD_W-bit response onto MISO. Compared with the previous block it adds width generalisation, a one-cycle rx_valid strobe, a tx_valid latch handshake, a frame-abort error flag and fully reset state.

## Interface
- PAYLOAD_W, 8, payload width in bits; the frame width is RX_W = PAYLOAD_W+2 (2-bit command followed by payload, sent MSB first).
- CNT_W, $clog2(RX_W+PAYLOAD_W+1), width of the bit counter.
- clk  in  1  SPI bit clock; all sampling and driving happens on the posedge.
- rst_n  in  1  asynchronous, active-low reset.
- SS_n  in  1  slave select, active low; frame boundary.
- MOSI  in  1  serial data from the master.
- MISO  out  1  serial read data to the master.
- rx_data  out  RX_W  last complete received frame, {cmd[1:0], payload}.
- rx_valid  out  1  one-cycle strobe: rx_data was updated.
- tx_data  in  PAYLOAD_W  read-response data.
- tx_valid  in  1  tx_data is valid; sampled only while waiting for a response.
- frame_err  out  1  one-cycle strobe: SS_n deasserted before RX_W bits were received.

## Operation
- Reset values: cs=IDLE, MISO=0, rx_valid=0, rx_data=0, frame_err=0, counter=0, shift register=0, rd_addr_seen=0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA. Sequential encoding.
- IDLE -> CHK_CMD when SS_n=0; otherwise stays in IDLE.
- Any state other than IDLE -> IDLE on any edge where SS_n=1.
  - The MOSI bit sampled on that edge is discarded.
  - counter is cleared and MISO is set to 0.
- CHK_CMD samples frame bit RX_W-1 (cmd[1]) into the shift register and sets counter=1.
  - MOSI=0 -> WRITE.
  - MOSI=1 with rd_addr_seen=1 -> READ_DATA.
  - MOSI=1 with rd_addr_seen=0 -> READ_ADD.
- WRITE, READ_ADD and READ_DATA each shift MOSI in MSB first, one bit per edge, until counter reaches RX_W.
  - On the edge that captures bit 0: rx_data <= complete word, rx_valid <= 1.
  - In READ_ADD, the same edge also sets rd_addr_seen <= 1.
  - In WRITE and READ_ADD, further MOSI bits are ignored until SS_n rises.
- READ_DATA response phase:
  - After the frame completes, the block waits for tx_valid=1. Waiting is unbounded; MISO=0 while waiting.
  - On the first edge with tx_valid=1: latch tx_data, drive MISO <= tx_data[PAYLOAD_W-1].
  - Each following edge drives the next lower bit.
  - On the edge after bit 0 is driven: MISO <= 0 and rd_addr_seen <= 0. tx_valid is then ignored until the next frame.
- rd_addr_seen persists across frames and is changed only by READ_ADD completion, read-response completion, or reset.
  - A read-data frame aborted before its response completes leaves rd_addr_seen=1.
- rx_data holds its value between frames; only a completed frame updates it.
- Command bits are passed through unchanged. Checking cmd[0] against the selected state is the downstream block's job.

## Timing
- Edge E0: cs=IDLE, SS_n=0 sampled. E1: first frame bit sampled. Ek: bit RX_W-k sampled.
- rx_valid is high from E(RX_W) to E(RX_W+1): exactly one cycle.
- For the first response bit, MISO is valid one edge after tx_valid is sampled high. The full response occupies PAYLOAD_W consecutive cycles.
- frame_err rises on the edge that samples SS_n=1 while cs≠IDLE and counter<RX_W, and stays high for one cycle.
- Simultaneous SS_n=1 and last bit: the frame is aborted, with no rx_valid and frame_err=1.
- Asynchronous reset mid-frame or mid-response forces all reset values immediately. The next frame starts from IDLE.

## Test plan
- Write, PAYLOAD_W=8: SS_n low, send bits 00_1010_0101 -> rx_data=0x0A5, rx_valid high for exactly one cycle after the 10th bit, MISO=0 throughout, rd_addr_seen=0.
- Read address: send 10_0000_1111 -> rx_data=0x20F, rx_valid one cycle, rd_addr_seen=1. Raise SS_n -> IDLE.
- Read data: after the read-address frame, send 11_0000_0000 -> rx_data=0x300, rx_valid pulse. Then tx_data=0xC3 with tx_valid=1 for 1 cycle -> MISO=1,1,0,0,0,0,1,1 on consecutive cycles, then 0; rd_addr_seen=0.
- Abort and ordering: send 5 bits, then SS_n=1 -> frame_err for one cycle, no rx_valid, rx_data unchanged. With no prior read address, send cmd bit 1 -> READ_ADD path, MISO stays 0.
- Reset: assert rst_n=0 during the MISO response of 0xC3 -> MISO=0 and rx_valid=0 immediately. Next frame 11_xxxx... takes the READ_ADD path.
- PAYLOAD_W=16: write frame 01 followed by 0xBEEF -> rx_data=0x1BEEF after 18 bits. A read response of 0x8001 gives MISO 1, fourteen 0s, then 1.

Source files
------------

// File: rtl/spi_slave_param.sv
// spi_slave_param: parametrised SPI slave.
// Receives {cmd[1:0], payload} frames MSB first on MOSI and presents them on
// rx_data with a one-cycle rx_valid strobe. A read-data command is followed by
// a PAYLOAD_W-bit response on MISO once tx_valid supplies the data. Dropping
// SS_n before a frame is complete pulses frame_err.
module spi_slave_param #(
    parameter int PAYLOAD_W = 8,
    parameter int CNT_W     = $clog2(2 * PAYLOAD_W + 3)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   SS_n,
    input  logic                   MOSI,
    output logic                   MISO,
    output logic [PAYLOAD_W+1:0]   rx_data,
    output logic                   rx_valid,
    input  logic [PAYLOAD_W-1:0]   tx_data,
    input  logic                   tx_valid,
    output logic                   frame_err
);

    localparam int RX_W = PAYLOAD_W + 2;

    // Counter milestones: RX_W bits received, then PAYLOAD_W response bits.
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_RXW  = CNT_W'(RX_W);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(RX_W - 1);
    localparam logic [CNT_W-1:0] C_DONE = CNT_W'(RX_W + PAYLOAD_W);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_next;
    logic [RX_W-1:0]        r_shift;
    logic [RX_W-1:0]        w_shift_next;
    logic [RX_W-1:0]        w_shift_in;
    logic [RX_W-1:0]        r_rx_data;
    logic [RX_W-1:0]        w_rx_data_next;
    logic                   r_rx_valid;
    logic                   w_rx_valid_next;
    logic                   r_frame_err;
    logic                   w_frame_err_next;
    logic                   r_rd_seen;
    logic                   w_rd_seen_next;
    logic                   r_miso;
    logic                   w_miso_next;
    logic [PAYLOAD_W-1:0]   r_tx_sr;
    logic [PAYLOAD_W-1:0]   w_tx_sr_next;

    assign MISO      = r_miso;
    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;

    // Current frame word with the newly sampled MOSI bit appended at the LSB.
    assign w_shift_in = {r_shift[RX_W-2:0], MOSI};

    // State and datapath registers; every bit has a defined reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_rd_seen   <= 1'b0;
            r_miso      <= 1'b0;
            r_tx_sr     <= '0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_shift     <= w_shift_next;
            r_rx_data   <= w_rx_data_next;
            r_rx_valid  <= w_rx_valid_next;
            r_frame_err <= w_frame_err_next;
            r_rd_seen   <= w_rd_seen_next;
            r_miso      <= w_miso_next;
            r_tx_sr     <= w_tx_sr_next;
        end
    end

    // Next-state and datapath decode; strobes default low every cycle.
    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_shift_next     = r_shift;
        w_rx_data_next   = r_rx_data;
        w_rx_valid_next  = 1'b0;
        w_frame_err_next = 1'b0;
        w_rd_seen_next   = r_rd_seen;
        w_miso_next      = r_miso;
        w_tx_sr_next     = r_tx_sr;

        if ((r_state != IDLE) && SS_n) begin
            // Frame boundary: the bit sampled now is dropped. An incomplete
            // frame (including one ending on its last bit) is an error.
            w_state_next     = IDLE;
            w_cnt_next       = '0;
            w_miso_next      = 1'b0;
            w_frame_err_next = (r_cnt < C_RXW);
        end else begin
            case (r_state)
                IDLE: begin
                    if (!SS_n) begin
                        w_state_next = CHK_CMD;
                    end
                end
                CHK_CMD: begin
                    // cmd[1] picks the path; a read after a read address is
                    // treated as read data.
                    w_shift_next = w_shift_in;
                    w_cnt_next   = C_ONE;
                    if (!MOSI) begin
                        w_state_next = WRITE;
                    end else if (r_rd_seen) begin
                        w_state_next = READ_DATA;
                    end else begin
                        w_state_next = READ_ADD;
                    end
                end
                WRITE, READ_ADD, READ_DATA: begin
                    if (r_cnt < C_RXW) begin
                        w_shift_next = w_shift_in;
                        w_cnt_next   = r_cnt + C_ONE;
                        if (r_cnt == C_LAST) begin
                            w_rx_data_next  = w_shift_in;
                            w_rx_valid_next = 1'b1;
                            if (r_state == READ_ADD) begin
                                w_rd_seen_next = 1'b1;
                            end
                        end
                    end else if (r_state == READ_DATA) begin
                        if (r_cnt == C_RXW) begin
                            // Wait indefinitely for response data.
                            if (tx_valid) begin
                                w_miso_next  = tx_data[PAYLOAD_W-1];
                                w_tx_sr_next = tx_data << 1;
                                w_cnt_next   = r_cnt + C_ONE;
                            end
                        end else if (r_cnt < C_DONE) begin
                            w_miso_next  = r_tx_sr[PAYLOAD_W-1];
                            w_tx_sr_next = r_tx_sr << 1;
                            w_cnt_next   = r_cnt + C_ONE;
                        end else begin
                            // Response finished: park MISO low, ignore
                            // tx_valid until the next frame.
                            w_miso_next    = 1'b0;
                            w_rd_seen_next = 1'b0;
                        end
                    end
                end
                default: begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                    w_miso_next  = 1'b0;
                end
            endcase
        end
    end

endmodule
